// File: rtl/rtc_calendar_core_if.sv
// rtc_calendar_core_if
//   Field access bus for the RTC calendar core: 6-bit load/readback path
//   plus the load strobe, read strobe and field select.
//
//   Signals
//     load     write strobe, din goes to field sel at this edge
//     rd       read strobe, field sel is captured into dout at this edge
//     sel[2:0] field select (0 sec, 1 min, 2 hour, 3 day, 4 date, 5 month, 6 year)
//     din[5:0] load data, binary
//     dout[5:0] registered readback
//     load_err one-cycle pulse after a rejected load
//
//   Modports
//     master  host side (drives strobes and data)
//     slave   core side (returns readback and error)

interface rtc_calendar_core_if;
  logic       load;
  logic       rd;
  logic [2:0] sel;
  logic [5:0] din;
  logic [5:0] dout;
  logic       load_err;

  modport master (
    output load, rd, sel, din,
    input  dout, load_err
  );

  modport slave (
    input  load, rd, sel, din,
    output dout, load_err
  );
endinterface

// File: rtl/rtc_calendar_core.sv
// rtc_calendar_core
//   Time-of-day and calendar counter chain (sec, min, hour, day-of-week,
//   date, month, year) driven by a prescaled one-second tick. Fields are
//   loaded and read back over a 6-bit bus; loads are range-checked and month
//   lengths follow the year[1:0]==0 leap rule (year 0 = 2000).
//
//   Optional build macro: RTC_ALARM_EN adds a daily hour:minute alarm.
//
//   Ports
//     clk        system clock, rising edge
//     clear_n    asynchronous active-low reset
//     enable     1 = prescaler and counters run, 0 = hold (bus still works)
//     hour12     display mode: 1 = 12-hour, 0 = 24-hour
//     bus        field access bus (rtc_calendar_core_if.slave)
//     sec_tick   one-cycle pulse on every seconds increment
//     day_tick   one-cycle pulse with sec_tick when the date advanced
//     hour_disp  display hour, 0-23 or 1-12
//     pm         internal hour >= 12
//   RTC_ALARM_EN only
//     alarm_set  alarm programming strobe: hour then minute on din
//     alarm_on   alarm enable
//     alarm      one-cycle pulse when a tick reaches alarm_hour:alarm_min:00

module rtc_calendar_core #(
  parameter int TICK_DIV = 50,
  parameter int PRESC_W  = 16,
  parameter int YEAR_MAX = 63
) (
  input  logic               clk,
  input  logic               clear_n,
  input  logic               enable,
  input  logic               hour12,
  rtc_calendar_core_if.slave bus,
  output logic               sec_tick,
  output logic               day_tick,
  output logic [4:0]         hour_disp,
  output logic               pm
`ifdef RTC_ALARM_EN
  ,
  input  logic               alarm_set,
  input  logic               alarm_on,
  output logic               alarm
`endif
);

  localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(TICK_DIV - 1);
  localparam logic [5:0]         YEAR_TOP = 6'(YEAR_MAX);

  localparam logic [2:0] SEL_SEC   = 3'd0;
  localparam logic [2:0] SEL_MIN   = 3'd1;
  localparam logic [2:0] SEL_HOUR  = 3'd2;
  localparam logic [2:0] SEL_DAY   = 3'd3;
  localparam logic [2:0] SEL_DATE  = 3'd4;
  localparam logic [2:0] SEL_MONTH = 3'd5;
  localparam logic [2:0] SEL_YEAR  = 3'd6;

  logic [PRESC_W-1:0] presc;
  logic [5:0]         sec;
  logic [5:0]         min;
  logic [4:0]         hour;
  logic [2:0]         day;
  logic [4:0]         date;
  logic [3:0]         month;
  logic [5:0]         year;
  logic [5:0]         dout_r;
  logic               load_err_r;

  logic [PRESC_W-1:0] presc_nx;
  logic               tick_now;
  logic               c_min, c_hour, c_day, c_month, c_year;
  logic [5:0]         sec_casc, min_casc, year_casc;
  logic [4:0]         hour_casc, date_casc;
  logic [2:0]         day_casc;
  logic [3:0]         month_casc;
  logic [4:0]         cur_len, nx_len;
  logic               ld_ok;
  logic               ld_sec, ld_min, ld_hour, ld_day, ld_date, ld_month, ld_year;
  logic [5:0]         sec_nx, min_nx, year_nx;
  logic [4:0]         hour_nx, date_pre, date_nx;
  logic [2:0]         day_nx;
  logic [3:0]         month_nx;
  logic [5:0]         rd_val;
  logic               err_nx;
  logic               alarm_err;

  function automatic logic [4:0] month_len(input logic [3:0] mo, input logic [5:0] yr);
    case (mo)
      4'd2:                     month_len = (yr[1:0] == 2'b00) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: month_len = 5'd30;
      default:                  month_len = 5'd31;
    endcase
  endfunction

  // Cascade: every carry is decided from the current register values, so
  // the whole chain settles on one edge.
  always_comb begin
    tick_now = enable && (presc == PRESC_TC);
    cur_len  = month_len(month, year);

    c_min   = tick_now && (sec == 6'd59);
    c_hour  = c_min && (min == 6'd59);
    c_day   = c_hour && (hour == 5'd23);
    c_month = c_day && (date == cur_len);
    c_year  = c_month && (month == 4'd12);

    sec_casc   = tick_now ? ((sec == 6'd59) ? 6'd0 : sec + 6'd1) : sec;
    min_casc   = c_min ? ((min == 6'd59) ? 6'd0 : min + 6'd1) : min;
    hour_casc  = c_hour ? ((hour == 5'd23) ? 5'd0 : hour + 5'd1) : hour;
    day_casc   = c_day ? ((day == 3'd6) ? 3'd0 : day + 3'd1) : day;
    date_casc  = c_day ? ((date == cur_len) ? 5'd1 : date + 5'd1) : date;
    month_casc = c_month ? ((month == 4'd12) ? 4'd1 : month + 4'd1) : month;
    year_casc  = c_year ? ((year == YEAR_TOP) ? 6'd0 : year + 6'd1) : year;
  end

  // Load range check; date is checked against the month currently held.
  always_comb begin
    ld_ok = 1'b0;
    case (bus.sel)
      SEL_SEC, SEL_MIN: ld_ok = (bus.din <= 6'd59);
      SEL_HOUR:         ld_ok = (bus.din <= 6'd23);
      SEL_DAY:          ld_ok = (bus.din <= 6'd6);
      SEL_DATE:         ld_ok = (bus.din != 6'd0) && (bus.din <= {1'b0, cur_len});
      SEL_MONTH:        ld_ok = (bus.din != 6'd0) && (bus.din <= 6'd12);
      SEL_YEAR:         ld_ok = (bus.din <= YEAR_TOP);
      default:          ld_ok = 1'b0;
    endcase
  end

  always_comb begin
    ld_sec   = bus.load && ld_ok && (bus.sel == SEL_SEC);
    ld_min   = bus.load && ld_ok && (bus.sel == SEL_MIN);
    ld_hour  = bus.load && ld_ok && (bus.sel == SEL_HOUR);
    ld_day   = bus.load && ld_ok && (bus.sel == SEL_DAY);
    ld_date  = bus.load && ld_ok && (bus.sel == SEL_DATE);
    ld_month = bus.load && ld_ok && (bus.sel == SEL_MONTH);
    ld_year  = bus.load && ld_ok && (bus.sel == SEL_YEAR);
  end

  // A load replaces only its own field; carries out of that field's old
  // value still reach the fields above it.
  always_comb begin
    sec_nx   = ld_sec   ? bus.din      : sec_casc;
    min_nx   = ld_min   ? bus.din      : min_casc;
    hour_nx  = ld_hour  ? bus.din[4:0] : hour_casc;
    day_nx   = ld_day   ? bus.din[2:0] : day_casc;
    date_pre = ld_date  ? bus.din[4:0] : date_casc;
    month_nx = ld_month ? bus.din[3:0] : month_casc;
    year_nx  = ld_year  ? bus.din      : year_casc;

    // Month/year load may shorten the month under the current date.
    nx_len  = month_len(month_nx, year_nx);
    date_nx = ((ld_month || ld_year) && (date_pre > nx_len)) ? nx_len : date_pre;

    if (ld_sec || tick_now) begin
      presc_nx = '0;
    end else if (enable) begin
      presc_nx = presc + PRESC_W'(1);
    end else begin
      presc_nx = presc;
    end

    err_nx = (bus.load && !ld_ok) || alarm_err;
  end

  always_comb begin
    rd_val = 6'd0;
    case (bus.sel)
      SEL_SEC:   rd_val = sec;
      SEL_MIN:   rd_val = min;
      SEL_HOUR:  rd_val = {1'b0, hour};
      SEL_DAY:   rd_val = {3'b000, day};
      SEL_DATE:  rd_val = {1'b0, date};
      SEL_MONTH: rd_val = {2'b00, month};
      SEL_YEAR:  rd_val = year;
      default:   rd_val = 6'd0;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      presc      <= '0;
      sec        <= 6'd0;
      min        <= 6'd0;
      hour       <= 5'd0;
      day        <= 3'd6;
      date       <= 5'd1;
      month      <= 4'd1;
      year       <= 6'd0;
      dout_r     <= 6'd0;
      load_err_r <= 1'b0;
      sec_tick   <= 1'b0;
      day_tick   <= 1'b0;
    end else begin
      presc      <= presc_nx;
      sec        <= sec_nx;
      min        <= min_nx;
      hour       <= hour_nx;
      day        <= day_nx;
      date       <= date_nx;
      month      <= month_nx;
      year       <= year_nx;
      load_err_r <= err_nx;
      sec_tick   <= tick_now;
      day_tick   <= c_day;
      // rd_val is built from pre-edge registers, so rd+load returns the old value
      if (bus.rd) begin
        dout_r <= rd_val;
      end
    end
  end

  assign bus.dout     = dout_r;
  assign bus.load_err = load_err_r;

  always_comb begin
    hour_disp = hour;
    if (hour12) begin
      if (hour == 5'd0) begin
        hour_disp = 5'd12;
      end else if (hour > 5'd12) begin
        hour_disp = hour - 5'd12;
      end
    end
  end

  assign pm = (hour >= 5'd12);

`ifdef RTC_ALARM_EN
  // Alarm programming sequencer
  //   state   | meaning
  //   AL_HOUR | next alarm_set edge takes alarm_hour from din
  //   AL_MIN  | next edge takes alarm_min if alarm_set, else abandons the pair
  localparam logic [0:0] AL_HOUR = 1'b0;
  localparam logic [0:0] AL_MIN  = 1'b1;

  logic [0:0] al_state;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       alarm_hit;

  always_comb begin
    alarm_err = 1'b0;
    if (alarm_set) begin
      if (al_state == AL_HOUR) begin
        alarm_err = (bus.din > 6'd23);
      end else begin
        alarm_err = (bus.din > 6'd59);
      end
    end
    // Match on the values the tick itself produces.
    alarm_hit = tick_now && alarm_on && (sec_casc == 6'd0) &&
                (min_casc == alarm_min) && (hour_casc == alarm_hour);
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      al_state   <= AL_HOUR;
      alarm_hour <= 5'd0;
      alarm_min  <= 6'd0;
      alarm      <= 1'b0;
    end else begin
      alarm <= alarm_hit;
      if (alarm_set) begin
        if (al_state == AL_HOUR) begin
          if (bus.din <= 6'd23) begin
            alarm_hour <= bus.din[4:0];
          end
          al_state <= AL_MIN;
        end else begin
          if (bus.din <= 6'd59) begin
            alarm_min <= bus.din;
          end
          al_state <= AL_HOUR;
        end
      end else begin
        al_state <= AL_HOUR;
      end
    end
  end
`else
  assign alarm_err = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_calendar_core.sv
module tb_rtc_calendar_core;
  localparam int TD   = 4;
  localparam int YMAX = 63;

  logic       clk = 1'b0;
  logic       clear_n;
  logic       enable;
  logic       hour12;
  logic       sec_tick;
  logic       day_tick;
  logic [4:0] hour_disp;
  logic       pm;
`ifdef RTC_ALARM_EN
  logic       alarm_set;
  logic       alarm_on;
  logic       alarm;
`endif

  rtc_calendar_core_if bus();

  rtc_calendar_core #(.TICK_DIV(TD), .PRESC_W(16), .YEAR_MAX(YMAX)) dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .enable    (enable),
    .hour12    (hour12),
    .bus       (bus),
    .sec_tick  (sec_tick),
    .day_tick  (day_tick),
    .hour_disp (hour_disp),
    .pm        (pm)
`ifdef RTC_ALARM_EN
    ,
    .alarm_set (alarm_set),
    .alarm_on  (alarm_on),
    .alarm     (alarm)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int dout;
    int err;
    int st;
    int dt;
    int hd;
    int pm;
    int al;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // reference model: calendar as plain integers
  int m_sec, m_min, m_hour, m_day, m_date, m_month, m_year;
  int m_presc, m_dout;
  int m_al_hour, m_al_min, m_al_phase;
  bit h12_req = 0;
  bit a_set_req = 0;
  bit a_on_req = 0;

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic int mlen(input int mo, input int yr);
    if (mo == 2) return (yr % 4 == 0) ? 29 : 28;
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    return 31;
  endfunction

  task automatic model_reset();
    m_sec = 0; m_min = 0; m_hour = 0; m_day = 6;
    m_date = 1; m_month = 1; m_year = 0;
    m_presc = 0; m_dout = 0;
    m_al_hour = 0; m_al_min = 0; m_al_phase = 0;
  endtask

  task automatic model_edge(input bit en, input bit ld, input bit rdx, input int s, input int d);
    exp_t e;
    bit tick, ok, rolled, al_err;
    int tod;
    tick = en && (m_presc == TD - 1);
    case (s)
      0, 1:    ok = (d <= 59);
      2:       ok = (d <= 23);
      3:       ok = (d <= 6);
      4:       ok = (d >= 1) && (d <= mlen(m_month, m_year));
      5:       ok = (d >= 1) && (d <= 12);
      6:       ok = (d <= YMAX);
      default: ok = 0;
    endcase
    if (rdx) begin
      case (s)
        0: m_dout = m_sec;
        1: m_dout = m_min;
        2: m_dout = m_hour;
        3: m_dout = m_day;
        4: m_dout = m_date;
        5: m_dout = m_month;
        6: m_dout = m_year;
        default: m_dout = 0;
      endcase
    end
    rolled = 0;
    if (tick) begin
      tod = m_hour * 3600 + m_min * 60 + m_sec + 1;
      if (tod == 86400) begin
        tod = 0;
        rolled = 1;
        m_day = (m_day + 1) % 7;
        if (m_date == mlen(m_month, m_year)) begin
          m_date = 1;
          if (m_month == 12) begin
            m_month = 1;
            m_year = (m_year == YMAX) ? 0 : m_year + 1;
          end else begin
            m_month++;
          end
        end else begin
          m_date++;
        end
      end
      m_hour = tod / 3600;
      m_min  = (tod / 60) % 60;
      m_sec  = tod % 60;
    end
    e.al = 0;
    al_err = 0;
`ifdef RTC_ALARM_EN
    e.al = (tick && a_on_req && m_sec == 0 && m_min == m_al_min && m_hour == m_al_hour) ? 1 : 0;
    if (a_set_req) begin
      if (m_al_phase == 0) begin
        if (d <= 23) m_al_hour = d; else al_err = 1;
        m_al_phase = 1;
      end else begin
        if (d <= 59) m_al_min = d; else al_err = 1;
        m_al_phase = 0;
      end
    end else begin
      m_al_phase = 0;
    end
`endif
    if (tick) m_presc = 0;
    else if (en) m_presc++;
    if (ld && ok) begin
      case (s)
        0: begin m_sec = d; m_presc = 0; end
        1: m_min = d;
        2: m_hour = d;
        3: m_day = d;
        4: m_date = d;
        5: m_month = d;
        6: m_year = d;
        default: ;
      endcase
      if ((s == 5 || s == 6) && m_date > mlen(m_month, m_year))
        m_date = mlen(m_month, m_year);
    end
    e.dout = m_dout;
    e.err  = ((ld && !ok) || al_err) ? 1 : 0;
    e.st   = tick ? 1 : 0;
    e.dt   = rolled ? 1 : 0;
    e.hd   = h12_req ? ((m_hour % 12 == 0) ? 12 : m_hour % 12) : m_hour;
    e.pm   = (m_hour >= 12) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  // Monitor: every edge produces one response, compared half a cycle later.
  always @(negedge clk) begin : mon
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("dout", int'(bus.dout), e.dout);
      chk("load_err", int'(bus.load_err), e.err);
      chk("sec_tick", int'(sec_tick), e.st);
      chk("day_tick", int'(day_tick), e.dt);
      chk("hour_disp", int'(hour_disp), e.hd);
      chk("pm", int'(pm), e.pm);
`ifdef RTC_ALARM_EN
      chk("alarm", int'(alarm), e.al);
`endif
    end
  end

  task automatic step(input bit en, input bit ld, input bit rdx, input int s, input int d);
    #1;
    enable   = en;
    hour12   = h12_req;
    bus.load = ld;
    bus.rd   = rdx;
    bus.sel  = 3'(s);
    bus.din  = 6'(d);
`ifdef RTC_ALARM_EN
    alarm_set = a_set_req;
    alarm_on  = a_on_req;
`endif
    @(posedge clk);
    model_edge(en, ld, rdx, s, d);
    @(negedge clk);
  endtask

  task automatic ld(input int s, input int d);
    step(0, 1, 0, s, d);
  endtask

  task automatic rdf(input int s);
    step(0, 0, 1, s, 0);
  endtask

  task automatic read_all();
    for (int s = 0; s < 8; s++) rdf(s);
  endtask

  task automatic set_time(input int h, input int mi, input int s);
    ld(2, h);
    ld(1, mi);
    ld(0, s);
  endtask

  task automatic run_en(input int n);
    for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, actual %0t required < 2000000", $time);
    $fatal(1);
  end

  initial begin
    clear_n = 1'b0; enable = 1'b0; hour12 = 1'b0;
    bus.load = 1'b0; bus.rd = 1'b0; bus.sel = 3'd0; bus.din = 6'd0;
`ifdef RTC_ALARM_EN
    alarm_set = 1'b0; alarm_on = 1'b0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    #1 clear_n = 1'b1;

    // disturb state, then reset mid-count
    ld(0, 30);
    ld(4, 15);
    rdf(0);
    run_en(2);
    #3 clear_n = 1'b0;
    model_reset();
    #1;
    chk("rst_dout", int'(bus.dout), 0);
    chk("rst_load_err", int'(bus.load_err), 0);
    chk("rst_sec_tick", int'(sec_tick), 0);
    chk("rst_day_tick", int'(day_tick), 0);
    chk("rst_hour_disp", int'(hour_disp), 0);
    repeat (2) @(negedge clk);
    #1 clear_n = 1'b1;
    read_all();
    run_en(TD + 1);

    // full wrap on new year's eve of the last year
    ld(6, 63); ld(5, 12); ld(4, 31); ld(3, 6);
    set_time(23, 59, 59);
    run_en(TD);
    read_all();

    // leap February
    ld(6, 4); ld(5, 2); ld(4, 28);
    set_time(23, 59, 59); run_en(TD); rdf(4); rdf(5);
    set_time(23, 59, 59); run_en(TD); rdf(4); rdf(5);
    // non-leap February
    ld(6, 5); ld(5, 2); ld(4, 28);
    set_time(23, 59, 59); run_en(TD); rdf(4); rdf(5);

    // rejected loads and date clamp
    ld(1, 25); ld(1, 60); rdf(1);
    ld(5, 4); ld(4, 31); rdf(4); ld(4, 30); rdf(4);
    ld(5, 1); ld(4, 31); ld(6, 1); ld(5, 2); rdf(4);
    ld(7, 3); ld(3, 7); ld(5, 13); ld(5, 0); ld(4, 0);

    // rd and load together return the old value
    step(0, 1, 1, 1, 42);
    rdf(1);

    // 12-hour display
    h12_req = 1;
    ld(2, 0); ld(2, 12); ld(2, 13); ld(2, 23); ld(2, 1);
    h12_req = 0;
    ld(2, 13);

    // sec load on the tick edge, plain and with a pending carry
    run_en(1);
    for (int k = 0; k < TD && m_presc != TD - 1; k++) step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 10);
    rdf(0);
    run_en(TD + 1);
    ld(0, 59); ld(1, 5);
    run_en(TD - 1);
    step(1, 1, 0, 0, 10);
    rdf(0); rdf(1);

    // enable low holds timekeeping
    set_time(10, 0, 0);
    step(0, 0, 0, 0, 0);
    run_en(TD - 1);
    repeat (3 * TD) step(0, 0, 0, 0, 0);
    run_en(1);
    rdf(0);

`ifdef RTC_ALARM_EN
    a_set_req = 1;
    step(0, 0, 0, 0, 7);
    step(0, 0, 0, 0, 30);
    a_set_req = 0;
    a_on_req = 1;
    set_time(7, 29, 59);
    run_en(TD + 2);
    a_on_req = 0;
    set_time(7, 29, 59);
    run_en(TD + 2);
    a_set_req = 1;
    step(0, 0, 0, 0, 24);
    step(0, 0, 0, 0, 60);
    a_set_req = 0;
    a_on_req = 1;
`endif

    // randomized traffic with periodic near-midnight setups
    for (int i = 0; i < 2000; i++) begin
      h12_req = ($urandom % 2) == 1;
      if (i % 150 == 0) begin
        ld(6, $urandom % 64);
        ld(5, 1 + $urandom % 12);
        ld(4, (($urandom % 2) == 1) ? mlen(m_month, m_year) : 28);
        set_time(23, 59, 56 + $urandom % 4);
      end
      step(($urandom % 4) != 0, ($urandom % 6) == 0, ($urandom % 3) == 0,
           $urandom % 8, $urandom % 64);
    end

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: actual %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rtc_calendar_core.md
Name: rtc_calendar_core

Overview:
- Parametrised time-of-day and calendar counter chain: seconds, minutes, hours, day-of-week, date, month and year in one block.
- Replaces the per-field counters that previously shared the 6-bit databus.
- Adds leap-year-aware month lengths, range-checked field loads, registered field readback and 12/24-hour display.
- Sits between the system clock and the display/ALU datapath; all fields are loaded and read over a 6-bit bus.

Parameters:
TICK_DIV, 50, clk cycles per one-second tick (must be >= 2)
PRESC_W, 16, prescaler counter width; 2^PRESC_W must be >= TICK_DIV
YEAR_MAX, 63, last year value before wrap to 0 (year 0 = 2000; must be <= 63)

Ports:
clk  in  1  system clock, rising edge
clear_n  in  1  asynchronous active-low reset
enable  in  1  1 = timekeeping runs; 0 = prescaler and all counters hold
hour12  in  1  display mode: 1 = 12-hour, 0 = 24-hour
load  in  1  write strobe: din written to field sel at this edge
rd  in  1  read strobe: field sel captured into dout at this edge
sel  in  3  field: 0 sec, 1 min, 2 hour, 3 day, 4 date, 5 month, 6 year, 7 reserved
din  in  6  load data (binary)
dout  out  6  registered readback
load_err  out  1  one-cycle pulse: rejected load
sec_tick  out  1  one-cycle pulse on every seconds increment
day_tick  out  1  one-cycle pulse on date rollover
hour_disp  out  5  display hour: 0-23, or 1-12 in 12-hour mode
pm  out  1  1 when internal hour >= 12, in both modes

Behaviour:
- Reset (async, clear_n=0): sec=0, min=0, hour=0, day=6 (Saturday, 0=Sunday), date=1, month=1, year=0, prescaler=0, dout=0, load_err=0, sec_tick=0, day_tick=0. Giving 2000-01-01 00:00:00.
- Release of clear_n is synchronous in effect: the first count happens TICK_DIV enabled cycles after release.
- Prescaler:
  - Counts 0..TICK_DIV-1 while enable=1.
  - At TICK_DIV-1 it wraps to 0 and sec_tick=1 on the following cycle (registered, 1-cycle latency).
- Cascade: all carries resolve in the same edge; there is no ripple delay between fields.
  - sec 59->0 carries into min. min 59->0 carries into hour. hour 23->0 carries into date and day.
  - day 6->0.
  - date at month length -> 1, carries into month. Month length: Feb 29 if year[1:0]==0, else 28; Apr/Jun/Sep/Nov 30; other months 31.
  - month 12->1 carries into year. year YEAR_MAX->0.
  - day_tick pulses in the same cycle as sec_tick when a date rollover occurred.
- Load:
  - Writes at the edge where load=1. Ranges: sec/min 0-59, hour 0-23, day 0-6, date 1..current month length, month 1-12, year 0..YEAR_MAX. sel=7 is always rejected.
  - Out-of-range value: field unchanged, load_err=1 for the next cycle.
  - Loading sec also clears the prescaler.
  - If a seconds tick lands on the same edge, the load wins for the loaded field. Carries into higher fields still apply. A carry into the loaded field is discarded.
  - A month or year load that makes the current date exceed the new month length clamps date to that length, in the same edge.
- Read: when rd=1, dout takes the field value selected by sel at that edge (sel=7 returns 0). dout holds otherwise.
  - rd and load on the same edge: dout returns the pre-load value.
- Display (combinational from registers):
  - hour12=0: hour_disp = hour.
  - hour12=1: hour 0 -> 12, 1-12 -> same, 13-23 -> hour-12.
- enable=0: no ticks, no carries. Loads and reads still work.

Optional Feature:
- Macro RTC_ALARM_EN.
- Defined adds ports:
  - alarm_set in 1: at an edge with alarm_set=1, alarm_hour and alarm_min are taken from din, in two successive edges (first hour, then minute), each range-checked with load_err as above.
  - alarm_on in 1
  - alarm out 1: pulses one cycle when a tick produces hour==alarm_hour and min==alarm_min and sec==0 with alarm_on=1.
  - Alarm registers reset to 0.
- Not defined: none of these ports or registers exist; behaviour is otherwise identical.

Test Plan:
- clear_n low mid-count, then release, TICK_DIV=4 -> readback 0,0,0,6,1,1,0; first sec_tick exactly 4 enabled cycles after release.
- Load 23:59:59, day 6, date 31, month 12, year 63, then run one tick -> all wrap to 00:00:00, day 0, date 1, month 1, year 0; day_tick=1.
- year 4, month 2, date 28, 23:59:59, tick -> date 29; repeat from 23:59:59 -> date 1, month 3. Same test with year 5 -> Feb 28 goes to Mar 1.
- Load min=60 -> load_err pulses once, min unchanged. Load date=31 with month=4 -> rejected. Date 31 then month=2 with year=1 -> date clamps to 28.
- hour12=1 with hour 0, 12, 13 -> hour_disp 12/12/1, pm 0/1/1. Load sec=10 on the same edge as a tick -> sec=10, prescaler 0.
- RTC_ALARM_EN: alarm 07:30, alarm_on=1, time 07:29:59, one tick -> alarm pulses exactly once. With alarm_on=0 -> no pulse.
